// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit instruction-memory writes, core held in reset until loaded.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned KW = $clog2(DEPTH_WORDS + 1);

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_len;
    logic [15:0]     w_len_nxt;
    logic [15:0]     w_len_hdr;
    logic [KW-1:0]   r_word_cnt;
    logic [KW-1:0]   w_word_cnt_nxt;
    logic [1:0]      r_byte_cnt;
    logic [1:0]      w_byte_cnt_nxt;
    logic [23:0]     r_word;
    logic [23:0]     w_word_nxt;
    logic            w_fire;
    logic            w_last;
    logic            w_we_nxt;
    logic            r_s_ready;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_core_rst_n;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_sum_nxt;
`endif

    assign s_ready    = r_s_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst_n = r_core_rst_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, byte assembly and write-strobe decode
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_word_cnt_nxt = r_word_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_word_nxt     = r_word;
        w_we_nxt       = 1'b0;
        w_fire         = s_valid && r_s_ready;
        w_len_hdr      = {s_data, r_len[7:0]};
        w_last         = (16'(r_word_cnt) == (r_len - 16'd1));
`ifdef IMEM_LOADER_CSUM_EN
        w_sum_nxt      = r_sum;
`endif
        case (r_state)
            S_HDR0: begin
                if (w_fire) begin
                    w_len_nxt   = {8'h00, s_data};
                    w_state_nxt = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_fire) begin
                    w_len_nxt = w_len_hdr;
                    if (32'(w_len_hdr) > DEPTH_WORDS) begin
                        w_state_nxt = S_ERR;
                    end else if (w_len_hdr == 16'd0) begin
                        w_state_nxt = S_END;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_fire) begin
`ifdef IMEM_LOADER_CSUM_EN
                    w_sum_nxt = r_sum + s_data;
`endif
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0:    w_word_nxt[7:0]   = s_data;
                        2'd1:    w_word_nxt[15:8]  = s_data;
                        2'd2:    w_word_nxt[23:16] = s_data;
                        default: begin
                            w_we_nxt       = 1'b1;
                            w_word_cnt_nxt = r_word_cnt + KW'(1);
                            if (w_last) begin
                                w_state_nxt = S_END;
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_fire) begin
                    if ((r_sum + s_data) == 8'h00) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath and registered outputs; core release trails done by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len        <= 16'd0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= 2'd0;
            r_word       <= 24'd0;
            r_s_ready    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            r_sum        <= 8'h00;
`endif
        end else begin
            r_len        <= w_len_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_word       <= w_word_nxt;
            r_s_ready    <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            r_busy       <= (w_state_nxt != S_HDR0) && (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            r_done       <= (w_state_nxt == S_DONE);
            r_err        <= (w_state_nxt == S_ERR);
            r_core_rst_n <= r_done;
            r_we         <= w_we_nxt;
`ifdef IMEM_LOADER_CSUM_EN
            r_sum        <= w_sum_nxt;
`endif
            if (w_we_nxt) begin
                r_addr  <= BASE_ADDR + 32'({r_word_cnt, 2'b00});
                r_wdata <= {s_data, r_word};
            end
        end
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream boot loader that fills instruction memory before the single-cycle RV32 core starts. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit words. Each word is written through the core's instruction-memory write port (`input_instr`, `i_wr_e`, write address). While loading, the core is held in reset; it is released only after a complete, valid image has been written.

## Interface
- `DEPTH_WORDS`, default 256: instruction-memory capacity in words; maximum accepted image length.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; word k is written to `BASE_ADDR + 4*k`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `s_valid`, in, 1: upstream byte valid.
- `s_data`, in, 8: upstream byte.
- `s_ready`, out, 1: loader can accept a byte; a transfer occurs on `s_valid && s_ready` at a rising edge.
- `imem_we`, out, 1: one-cycle write strobe to instruction memory (drives `i_wr_e`).
- `imem_addr`, out, 32: write byte address.
- `imem_wdata`, out, 32: write data (drives `input_instr`).
- `core_rst_n`, out, 1: core reset, active-low; 0 holds the core.
- `busy`, out, 1: loading in progress.
- `done`, out, 1: image loaded; sticky until `rst`.
- `err`, out, 1: load aborted; sticky until `rst`.

## Operation
- **Stream format:**
  - `LEN_LO`, `LEN_HI`: 16-bit word count N.
  - 4*N payload bytes, little-endian per word. The first byte goes to `imem_wdata[7:0]`.
  - Optional checksum byte (see Configuration).
- **FSM states:** `HDR0`, `HDR1`, `DATA`, `CSUM` (macro only), `DONE`, `ERR`. Reset state is `HDR0`.
- **Transitions:**
  - `HDR0` → `HDR1` on accepting `LEN_LO`.
  - `HDR1`, on accepting `LEN_HI`:
    - N > `DEPTH_WORDS` → `ERR`.
    - N == 0 → `CSUM` if the macro is set, else `DONE`.
    - Otherwise → `DATA`.
  - `DATA`: 2-bit byte counter and word counter k (width clog2(`DEPTH_WORDS`+1)). On accepting byte 3 of word k, the assembled word is registered. If k == N-1, go to `CSUM` or `DONE`.
  - `CSUM` → `DONE` on match, `ERR` on mismatch.
  - `DONE` and `ERR` are terminal until `rst`.
- **`s_ready`:** 1 in `HDR0`/`HDR1`/`DATA`/`CSUM`. 0 in `DONE`/`ERR` and whenever `rst` is low. There is no backpressure inside a word; bytes may arrive back-to-back at one per cycle.
- **`busy`:** 1 in `HDR1`/`DATA`/`CSUM`, and in `HDR0` after at least one byte has been accepted. With the current state set, `busy` is therefore 0 in `HDR0`.
- **`s_valid` gaps:** allowed anywhere; the state is held.
- **Reset values:** `s_ready`=0, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `core_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- **Reset mid-operation:** the partial word is discarded, counters are cleared, and `core_rst_n` returns to 0. Words already written remain in memory.

## Timing
- **Write latency:** the byte completing word k is accepted at edge t. `imem_we`=1 for exactly the cycle after t, with `imem_addr`=`BASE_ADDR`+4k and `imem_wdata` = the assembled word.
- **Core release:** `done` and the `DONE` state are asserted the cycle after the final accepted byte. `core_rst_n` rises one cycle later, so at least one cycle separates the last `imem_we` from core release.
- **Error case:** `err` rises the cycle after the offending byte is accepted, and `core_rst_n` stays 0.
- **Address arithmetic:** `imem_addr` is 32-bit unsigned. k never exceeds `DEPTH_WORDS`-1, so no wrap occurs.

## Configuration
- **`IMEM_LOADER_CSUM_EN` defined:**
  - The loader keeps a running 8-bit sum mod 256 of all payload bytes, excluding the header.
  - The trailing checksum byte must equal the two's-complement of that sum, so that payload sum + checksum == 8'h00.
  - Match → `DONE`. Mismatch → `ERR`.
  - For N=0 the checksum byte must be 8'h00.
- **`IMEM_LOADER_CSUM_EN` undefined:** the `CSUM` state and adder are absent, no trailing byte is expected, and the last payload byte leads directly to `DONE`.

## Test plan
- **Two-word load:** N=2, bytes 13 05 00 00 93 05 10 00, sent back-to-back.
  - `imem_we` pulses writing 32'h00000513 @0x0 and 32'h00100593 @0x4.
  - `done`=1, then `core_rst_n`=1 one cycle later.
- **Zero length:** N=0 (00 00, plus 00 with the macro set).
  - No `imem_we` pulse; `done`=1; `core_rst_n` rises two cycles after the last byte.
- **Oversize image:** N=`DEPTH_WORDS`+1.
  - `err`=1 the cycle after `LEN_HI`; `s_ready`=0; no writes; `core_rst_n` stays 0.
- **Checksum mismatch (macro set):** N=1, word 32'h00000013, checksum 8'h00 instead of 8'hED.
  - One write occurs, then `err`=1 and `core_rst_n`=0.
- **Reset mid-load:**
  - Assert `rst` low after 2 payload bytes of word 1. All outputs return to reset values.
  - A fresh N=1 load then writes word 0 at `BASE_ADDR`.
- **Sparse `s_valid`:** random 0–5 cycle gaps between bytes.
  - Writes and data are identical to the back-to-back case; at most one `imem_we` per word.
